// File: rtl/ad9708_pkg.sv
// ---------------------------------------------------------------------------
// ad9708_pkg
// Shared definitions for the AD9708 playback scheduler:
//   - play_state_e : scheduler FSM states (IDLE / ARM / RUN / GAP)
//   - ERR_*        : bit positions inside the sticky err vector
//   - ERR_W        : err width (3 when AD9708_PLAY_WDOG_EN is defined, else 2)
//   - WORD_BYTES   : sender consumes whole 32-bit words
//   - WDOG_MARGIN  : slack cycles added to send_len for the RUN watchdog
// Optional feature macro: AD9708_PLAY_WDOG_EN
// ---------------------------------------------------------------------------
package ad9708_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_GAP  = 2'd3
    } play_state_e;

    localparam int ERR_LEN  = 0;  // rounded command length was zero
    localparam int ERR_ACK  = 1;  // sender never acknowledged send_start
`ifdef AD9708_PLAY_WDOG_EN
    localparam int ERR_WDOG = 2;  // sender never reported send_done
    localparam int ERR_W    = 3;
`else
    localparam int ERR_W    = 2;
`endif

    localparam int WORD_BYTES  = 4;
    localparam int WDOG_MARGIN = 64;

endpackage

// File: rtl/ad9708_play_ctrl_if.sv
// ---------------------------------------------------------------------------
// ad9708_play_ctrl_if
// Start/acknowledge handshake between the playback scheduler and the sender.
//   send_start : request level, held high until acknowledged
//   send_len   : burst length in bytes, stable while the request is up
//   st_clr     : one-cycle acknowledge from the sender (start accepted)
//   send_done  : one-cycle pulse from the sender when the burst is finished
// Handshake: the master raises send_start with send_len valid and keeps both
// unchanged until the cycle in which st_clr is seen high; that edge completes
// the transfer and send_start drops on it. st_clr while send_start is low
// carries no meaning and is ignored by the master.
// Modports: master (scheduler), slave (sender).
// ---------------------------------------------------------------------------
interface ad9708_play_ctrl_if #(
    parameter int LEN_W = 32
) ();
    logic             send_start;
    logic [LEN_W-1:0] send_len;
    logic             st_clr;
    logic             send_done;

    modport master (
        output send_start,
        output send_len,
        input  st_clr,
        input  send_done
    );

    modport slave (
        input  send_start,
        input  send_len,
        output st_clr,
        output send_done
    );
endinterface

// File: rtl/ad9708_play_timer.sv
// ---------------------------------------------------------------------------
// ad9708_play_timer
// Loadable down-counter with a zero flag. Counting stops at zero.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val this edge (wins over dec)
//   load_val  : value to load
//   dec       : decrement by one this edge when not already zero
//   zero      : count is zero
// ---------------------------------------------------------------------------
module ad9708_play_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/ad9708_play_ctrl.sv
// ---------------------------------------------------------------------------
// ad9708_play_ctrl
// Playback scheduler for the AD9708 DAC send path (dac_clk domain).
// Latches a software command (length, repeat, gap), then runs the sender
// start/ack handshake once per burst, counts bursts, requests a DMA refill
// between bursts and reports completion and sticky errors.
// Ports:
//   dac_clk, dac_rst          : clock, synchronous active-high reset
//   cmd_start / cmd_stop      : command pulses
//   cmd_len/cmd_repeat/cmd_gap: command fields (repeat 0 = until stopped)
//   snd (master)              : send_start/send_len/st_clr/send_done
//   dma_req                   : one-cycle refill request after a non-final burst
//   busy                      : scheduler not in IDLE
//   done_pulse                : one-cycle normal-completion pulse
//   burst_cnt                 : bursts completed since the last accepted start
//   err                       : sticky errors (bit0 length, bit1 ack timeout,
//                               bit2 RUN watchdog when enabled)
//   state_dbg                 : current FSM state
// Optional feature macro: AD9708_PLAY_WDOG_EN (RUN watchdog, 3-bit err).
// ---------------------------------------------------------------------------
module ad9708_play_ctrl
    import ad9708_pkg::*;
#(
    parameter int LEN_W       = 32,
    parameter int REP_W       = 16,
    parameter int GAP_W       = 16,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                 dac_clk,
    input  logic                 dac_rst,
    input  logic                 cmd_start,
    input  logic                 cmd_stop,
    input  logic [LEN_W-1:0]     cmd_len,
    input  logic [REP_W-1:0]     cmd_repeat,
    input  logic [GAP_W-1:0]     cmd_gap,
    ad9708_play_ctrl_if.master   snd,
    output logic                 dma_req,
    output logic                 busy,
    output logic                 done_pulse,
    output logic [REP_W-1:0]     burst_cnt,
    output logic [ERR_W-1:0]     err,
    output play_state_e          state_dbg
);
    localparam int ARM_W = $clog2(ACK_TIMEOUT) + 1;

    play_state_e      state_q, state_d;
    logic             send_start_q, send_start_d;
    logic [LEN_W-1:0] send_len_q, send_len_d;
    logic             dma_req_q, dma_req_d;
    logic             busy_q, busy_d;
    logic             done_pulse_q, done_pulse_d;
    logic [REP_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             stop_q, stop_d;

    logic             arm_load, arm_dec, arm_zero;
    logic             gap_load, gap_dec, gap_zero;
    logic [LEN_W-1:0] len_round;
    logic [REP_W-1:0] burst_inc;
    logic             last_burst;

    // Sender moves whole words: drop the sub-word byte bits.
    assign len_round  = cmd_len & ~LEN_W'(WORD_BYTES - 1);
    assign burst_inc  = (&burst_cnt_q) ? burst_cnt_q : burst_cnt_q + REP_W'(1);
    assign last_burst = (rep_q != '0) && (burst_inc == rep_q);

`ifdef AD9708_PLAY_WDOG_EN
    logic wd_load, wd_dec, wd_zero;
`endif

    always_comb begin
        state_d      = state_q;
        send_len_d   = send_len_q;
        dma_req_d    = 1'b0;
        done_pulse_d = 1'b0;
        burst_cnt_d  = burst_cnt_q;
        err_d        = err_q;
        rep_d        = rep_q;
        gap_d        = gap_q;
        stop_d       = stop_q;
        arm_load     = 1'b0;
        arm_dec      = 1'b0;
        gap_load     = 1'b0;
        gap_dec      = 1'b0;
`ifdef AD9708_PLAY_WDOG_EN
        wd_load      = 1'b0;
        wd_dec       = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    if (len_round == '0) begin
                        err_d[ERR_LEN] = 1'b1;
                    end else begin
                        err_d       = '0;
                        burst_cnt_d = '0;
                        send_len_d  = len_round;
                        rep_d       = cmd_repeat;
                        gap_d       = cmd_gap;
                        stop_d      = 1'b0;
                        arm_load    = 1'b1;
                        state_d     = ST_ARM;
                    end
                end
            end
            ST_ARM: begin
                if (cmd_stop) begin
                    done_pulse_d = 1'b1;
                    state_d      = ST_IDLE;
                end else if (snd.st_clr) begin
`ifdef AD9708_PLAY_WDOG_EN
                    wd_load = 1'b1;
`endif
                    state_d = ST_RUN;
                end else if (arm_zero) begin
                    err_d[ERR_ACK] = 1'b1;
                    state_d        = ST_IDLE;
                end else begin
                    arm_dec = 1'b1;
                end
            end
            ST_RUN: begin
                if (snd.send_done) begin
                    burst_cnt_d = burst_inc;
                    // A stop arriving with send_done still ends after this burst.
                    if (stop_q || cmd_stop || last_burst) begin
                        done_pulse_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        dma_req_d = 1'b1;
                        if (gap_q == '0) begin
                            arm_load = 1'b1;
                            state_d  = ST_ARM;
                        end else begin
                            gap_load = 1'b1;
                            state_d  = ST_GAP;
                        end
                    end
                end else begin
                    if (cmd_stop) begin
                        stop_d = 1'b1;
                    end
`ifdef AD9708_PLAY_WDOG_EN
                    if (wd_zero) begin
                        err_d[ERR_WDOG] = 1'b1;
                        state_d         = ST_IDLE;
                    end else begin
                        wd_dec = 1'b1;
                    end
`endif
                end
            end
            ST_GAP: begin
                if (cmd_stop) begin
                    done_pulse_d = 1'b1;
                    state_d      = ST_IDLE;
                end else if (gap_zero) begin
                    arm_load = 1'b1;
                    state_d  = ST_ARM;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered outputs follow the state being entered.
        send_start_d = (state_d == ST_ARM);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge dac_clk) begin
        if (dac_rst) begin
            state_q      <= ST_IDLE;
            send_start_q <= 1'b0;
            send_len_q   <= '0;
            dma_req_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_pulse_q <= 1'b0;
            burst_cnt_q  <= '0;
            err_q        <= '0;
            rep_q        <= '0;
            gap_q        <= '0;
            stop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            send_start_q <= send_start_d;
            send_len_q   <= send_len_d;
            dma_req_q    <= dma_req_d;
            busy_q       <= busy_d;
            done_pulse_q <= done_pulse_d;
            burst_cnt_q  <= burst_cnt_d;
            err_q        <= err_d;
            rep_q        <= rep_d;
            gap_q        <= gap_d;
            stop_q       <= stop_d;
        end
    end

    // Loaded with N-1 so the state lasts exactly N cycles before zero is acted on.
    ad9708_play_timer #(.W(ARM_W)) u_arm_timer (
        .clk      (dac_clk),
        .rst      (dac_rst),
        .load     (arm_load),
        .load_val (ARM_W'(ACK_TIMEOUT - 1)),
        .dec      (arm_dec),
        .zero     (arm_zero)
    );

    ad9708_play_timer #(.W(GAP_W)) u_gap_timer (
        .clk      (dac_clk),
        .rst      (dac_rst),
        .load     (gap_load),
        .load_val (gap_q - GAP_W'(1)),
        .dec      (gap_dec),
        .zero     (gap_zero)
    );

`ifdef AD9708_PLAY_WDOG_EN
    // One extra bit so send_len + margin cannot wrap.
    ad9708_play_timer #(.W(LEN_W + 1)) u_wd_timer (
        .clk      (dac_clk),
        .rst      (dac_rst),
        .load     (wd_load),
        .load_val ({1'b0, send_len_q} + (LEN_W + 1)'(WDOG_MARGIN - 1)),
        .dec      (wd_dec),
        .zero     (wd_zero)
    );
`endif

    assign snd.send_start = send_start_q;
    assign snd.send_len   = send_len_q;
    assign dma_req        = dma_req_q;
    assign busy           = busy_q;
    assign done_pulse     = done_pulse_q;
    assign burst_cnt      = burst_cnt_q;
    assign err            = err_q;
    assign state_dbg      = state_q;
endmodule

// File: tb/tb_ad9708_play_ctrl.sv
module tb_ad9708_play_ctrl;
    import ad9708_pkg::*;

    // ---------------- clock / reset ----------------
    logic dac_clk;
    logic dac_rst;

    initial dac_clk = 1'b0;
    always #5 dac_clk = ~dac_clk;

    // ---------------- DUT ----------------
    logic              cmd_start, cmd_stop;
    logic [31:0]       cmd_len;
    logic [15:0]       cmd_repeat, cmd_gap;
    logic              dma_req, busy, done_pulse;
    logic [15:0]       burst_cnt;
    logic [ERR_W-1:0]  err;
    play_state_e       state_dbg;

    ad9708_play_ctrl_if #(.LEN_W(32)) snd ();

    ad9708_play_ctrl dut (
        .dac_clk    (dac_clk),
        .dac_rst    (dac_rst),
        .cmd_start  (cmd_start),
        .cmd_stop   (cmd_stop),
        .cmd_len    (cmd_len),
        .cmd_repeat (cmd_repeat),
        .cmd_gap    (cmd_gap),
        .snd        (snd.master),
        .dma_req    (dma_req),
        .busy       (busy),
        .done_pulse (done_pulse),
        .burst_cnt  (burst_cnt),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    // ---------------- event monitor (mid-cycle) ----------------
    int   rises, dma_cnt, done_cnt;
    logic prev_ss;
    initial begin
        rises = 0; dma_cnt = 0; done_cnt = 0; prev_ss = 1'b0;
    end
    always @(negedge dac_clk) begin
        if (snd.send_start && !prev_ss) rises++;
        if (dma_req) dma_cnt++;
        if (done_pulse) done_cnt++;
        prev_ss = snd.send_start;
    end

    // ---------------- checking ----------------
    int checks, errors;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge dac_clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start(input logic [31:0] len, input logic [15:0] rep, input logic [15:0] gap);
        cmd_len = len; cmd_repeat = rep; cmd_gap = gap; cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic pulse_stop();
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (snd.send_start !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        check("send_start_seen", {63'd0, snd.send_start}, 64'd1);
    endtask

    task automatic ack(input int dly);
        run(dly);
        snd.st_clr = 1'b1;
        tick();
        snd.st_clr = 1'b0;
        check("send_start_drop_on_ack", {63'd0, snd.send_start}, 64'd0);
    endtask

    task automatic fin();
        snd.send_done = 1'b1;
        tick();
        snd.send_done = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int r0, d0, n0, lat;
        checks = 0; errors = 0;
        cmd_start = 0; cmd_stop = 0; cmd_len = 0; cmd_repeat = 0; cmd_gap = 0;
        snd.st_clr = 1'b0; snd.send_done = 1'b0;

        // reset state
        dac_rst = 1'b1;
        run(3);
        dac_rst = 1'b0;
        check("rst_busy",       {63'd0, busy}, 64'd0);
        check("rst_send_start", {63'd0, snd.send_start}, 64'd0);
        check("rst_send_len",   {32'd0, snd.send_len}, 64'd0);
        check("rst_err",        64'(err), 64'd0);
        check("rst_burst_cnt",  {48'd0, burst_cnt}, 64'd0);
        check("rst_state",      64'(state_dbg), 64'(ST_IDLE));
        tick();

        // len 1024, repeat 3, gap 10, ack after 2 cycles, done after 1024
        r0 = rises; d0 = dma_cnt; n0 = done_cnt;
        pulse_start(32'd1024, 16'd3, 16'd10);
        check("t1_busy",     {63'd0, busy}, 64'd1);
        check("t1_send_len", {32'd0, snd.send_len}, 64'd1024);
        for (int b = 0; b < 3; b++) begin
            wait_start();
            ack(2);
            run(1023);
            fin();
            check("t1_burst_cnt", {48'd0, burst_cnt}, 64'(b + 1));
            if (b < 2) begin
                check("t1_dma_req", {63'd0, dma_req}, 64'd1);
                lat = 1;
                while (!snd.send_start && lat < 64) begin
                    tick();
                    lat++;
                end
                check("t1_gap_latency", 64'(lat), 64'd11);
            end else begin
                check("t1_done_pulse", {63'd0, done_pulse}, 64'd1);
                check("t1_busy_fall",  {63'd0, busy}, 64'd0);
                check("t1_no_dma_last", {63'd0, dma_req}, 64'd0);
            end
        end
        tick();
        check("t1_done_one_cycle", {63'd0, done_pulse}, 64'd0);
        check("t1_rises", 64'(rises - r0), 64'd3);
        check("t1_dma_count", 64'(dma_cnt - d0), 64'd2);
        check("t1_done_count", 64'(done_cnt - n0), 64'd1);

        // length rounding to zero
        r0 = rises;
        pulse_start(32'd3, 16'd1, 16'd0);
        check("t2_err", 64'(err), 64'd1);
        check("t2_busy", {63'd0, busy}, 64'd0);
        run(3);
        check("t2_busy_later", {63'd0, busy}, 64'd0);
        check("t2_no_rise", 64'(rises - r0), 64'd0);

        // repeat 0, stop in the middle of the second burst
        pulse_start(32'd256, 16'd0, 16'd4);
        check("t3_err_cleared", 64'(err), 64'd0);
        wait_start();
        ack(1);
        run(20);
        pulse_start(32'd3, 16'd1, 16'd0);   // ignored while busy
        check("t3_start_ignored_err", 64'(err), 64'd0);
        run(234);
        fin();
        check("t3_dma_req", {63'd0, dma_req}, 64'd1);
        wait_start();
        ack(1);
        run(100);
        pulse_stop();
        check("t3_busy_after_stop", {63'd0, busy}, 64'd1);
        check("t3_still_run", 64'(state_dbg), 64'(ST_RUN));
        run(50);
        fin();
        check("t3_done_pulse", {63'd0, done_pulse}, 64'd1);
        check("t3_burst_cnt", {48'd0, burst_cnt}, 64'd2);
        check("t3_busy_fall", {63'd0, busy}, 64'd0);
        check("t3_no_dma", {63'd0, dma_req}, 64'd0);
        tick();

        // ack withheld: timeout after 1024 cycles in ARM
        n0 = done_cnt;
        pulse_start(32'd64, 16'd1, 16'd0);
        run(1023);
        check("t4_still_arm", {63'd0, snd.send_start}, 64'd1);
        tick();
        check("t4_err", 64'(err), 64'd2);
        check("t4_send_start", {63'd0, snd.send_start}, 64'd0);
        check("t4_idle", {63'd0, busy}, 64'd0);
        tick();
        check("t4_no_done", 64'(done_cnt - n0), 64'd0);

        // len 6 -> 4, gap 0: send_start back on the cycle after send_done
        pulse_start(32'd6, 16'd2, 16'd0);
        check("t5_send_len", {32'd0, snd.send_len}, 64'd4);
        wait_start();
        ack(0);
        run(3);
        fin();
        check("t5_rearm_next_cycle", {63'd0, snd.send_start}, 64'd1);
        check("t5_dma_req", {63'd0, dma_req}, 64'd1);
        ack(0);
        run(3);
        fin();
        check("t5_done", {63'd0, done_pulse}, 64'd1);
        check("t5_burst_cnt", {48'd0, burst_cnt}, 64'd2);
        tick();

        // stop while in GAP: immediate IDLE with done_pulse
        pulse_start(32'd8, 16'd0, 16'd20);
        wait_start();
        ack(0);
        run(7);
        fin();
        run(2);
        check("t7_in_gap", 64'(state_dbg), 64'(ST_GAP));
        pulse_stop();
        check("t7_busy", {63'd0, busy}, 64'd0);
        check("t7_done", {63'd0, done_pulse}, 64'd1);
        check("t7_burst_cnt", {48'd0, burst_cnt}, 64'd1);
        tick();

        // reset while in GAP
        pulse_start(32'd16, 16'd0, 16'd50);
        wait_start();
        ack(0);
        run(15);
        fin();
        run(3);
        check("t6_in_gap", 64'(state_dbg), 64'(ST_GAP));
        dac_rst = 1'b1;
        tick();
        check("t6_busy", {63'd0, busy}, 64'd0);
        check("t6_burst_cnt", {48'd0, burst_cnt}, 64'd0);
        check("t6_send_start", {63'd0, snd.send_start}, 64'd0);
        check("t6_send_len", {32'd0, snd.send_len}, 64'd0);
        dac_rst = 1'b0;
        tick();

        // reset clears a sticky error
        pulse_start(32'd2, 16'd1, 16'd0);
        check("t6_err_set", 64'(err), 64'd1);
        dac_rst = 1'b1;
        tick();
        check("t6_err_cleared", 64'(err), 64'd0);
        dac_rst = 1'b0;
        run(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ad9708_play_ctrl.md
Name: ad9708_play_ctrl

Overview:
- Playback scheduler for the AD9708 DAC send path, in the dac_clk domain next to the sender.
- Takes a software command: byte length, repeat count, inter-burst gap. Sequences the sender's send_start/send_len handshake once per burst.
- Counts completed bursts, requests a DMA refill per burst, and reports completion and errors.

Parameters:
- LEN_W, 32, width of length and internal sample counters
- REP_W, 16, width of repeat count and burst counter
- GAP_W, 16, width of inter-burst gap counter
- ACK_TIMEOUT, 1024, dac_clk cycles to wait for st_clr after raising send_start

Ports:
- dac_clk  in  1  single clock (DAC sample clock)
- dac_rst  in  1  synchronous active-high reset
- cmd_start  in  1  one-cycle pulse: latch command, begin playback
- cmd_stop  in  1  one-cycle pulse: graceful stop request
- cmd_len  in  LEN_W  bytes (samples) per burst
- cmd_repeat  in  REP_W  bursts to play; 0 = play until stopped
- cmd_gap  in  GAP_W  idle dac_clk cycles between bursts
- send_start  out  1  level to sender, held until acknowledged
- send_len  out  LEN_W  burst length to sender, stable while busy
- st_clr  in  1  sender acknowledge pulse (start accepted)
- send_done  in  1  one-cycle pulse: sender finished burst
- dma_req  out  1  one-cycle pulse: request DMA refill for next burst
- busy  out  1  high in any state other than IDLE
- done_pulse  out  1  one-cycle pulse when playback ends normally
- burst_cnt  out  REP_W  bursts completed since last cmd_start
- err  out  2  sticky: bit0 bad length, bit1 ack timeout; cleared by next accepted cmd_start

Behaviour:
- Clock and reset: already decided — one clock, dac_clk; reset dac_rst is synchronous and active-high.
- Reset values: state IDLE; all outputs 0; send_len 0; internal counters 0.
- States: IDLE, ARM, RUN, GAP.
- IDLE:
  - cmd_start latches cmd_len with bits[1:0] cleared (sender consumes 32-bit words), plus repeat and gap.
  - If the rounded length is 0: set err[0], stay IDLE, busy stays 0.
  - Otherwise: clear err and burst_cnt, load send_len, go ARM next cycle.
- ARM:
  - send_start=1.
  - On st_clr: send_start=0 the same edge, go RUN.
  - ACK_TIMEOUT cycles without st_clr: set err[1], send_start=0, go IDLE, no done_pulse.
- RUN:
  - On send_done: burst_cnt+1 (saturating at all-ones).
  - If stop is pending, or burst_cnt+1 == repeat with repeat≠0: done_pulse=1 next cycle, go IDLE.
  - Otherwise: dma_req=1 for one cycle, go GAP (or directly ARM if gap=0).
- GAP:
  - Counts cmd_gap cycles, then ARM.
  - Exactly cmd_gap idle cycles between the send_done cycle and the next send_start rise; latency is gap+1 cycles.
- cmd_stop:
  - In ARM or GAP: immediate return to IDLE, done_pulse=1.
  - In RUN: sets stop_pending; the current burst completes (sender cannot abort).
  - In IDLE: ignored.
- Simultaneous events:
  - cmd_start while busy: ignored.
  - send_done and cmd_stop in the same cycle: treated as stop pending, so playback ends after that burst.
  - st_clr outside ARM, or send_done outside RUN: ignored.
- Reset mid-playback: immediate IDLE, all outputs drop the next edge, sticky errors cleared.

Optional Feature:
- Macro: AD9708_PLAY_WDOG_EN.
- When defined: RUN watchdog counts cycles. If send_done is not seen within send_len + 64 cycles, err gains bit2 (err becomes 3 bits wide), done_pulse is suppressed, state goes IDLE.
- When undefined: RUN waits indefinitely for send_done; err is 2 bits.

Decomposition:
- Shared package ad9708_pkg holds:
  - state enum (IDLE/ARM/RUN/GAP)
  - error bit index constants
  - WORD_BYTES=4
  - WDOG_MARGIN=64
- Natural sub-module: ad9708_play_timer, a loadable down-counter with zero flag, instanced for the ARM timeout, the GAP count and the optional watchdog.

Test Plan:
- cmd_len=1024, repeat=3, gap=10, ack after 2 cycles, send_done after 1024 cycles -> three send_start rises; dma_req twice; burst_cnt=3; done_pulse once; busy falls.
- cmd_len=3 -> err=01, busy never asserts, send_start stays 0.
- cmd_len=256, repeat=0, cmd_stop mid second burst -> second burst completes; done_pulse one cycle after its send_done; burst_cnt=2.
- st_clr withheld -> after 1024 cycles in ARM: err=10, send_start=0, IDLE, no done_pulse.
- cmd_len=6 -> send_len=4; gap=0 -> send_start rises on the cycle after send_done.
- dac_rst asserted in GAP with err set -> next edge: busy=0, err=0, burst_cnt=0, send_start=0.
